// File: rtl/l2_out_arbiter.sv
// l2_out_arbiter: shares the single L2 NoC injection port between the three
// outbound L2 channels: responses, forwards and requests.
//
// A fixed priority of rsp > fwd > req selects one message per cycle. The
// selected message is registered in a one-entry elastic output stage and
// tagged with its source class. Giving responses top priority keeps response
// traffic making progress, which is what keeps the coherence protocol
// deadlock-free.
//
// Optional feature, enabled by defining the macro L2_OUT_AGING_EN:
//   A request starvation counter counts the cycles in which a pending request
//   is refused. When the counter reaches AGE_MAX, req is promoted above fwd,
//   giving the order rsp > req > fwd until that request is accepted.
//   Responses are never overtaken.
// Without the macro there is no counter, and the order is strictly
// rsp > fwd > req.

module l2_out_arbiter #(
  parameter int PKT_W   = 600,
  parameter int AGE_W   = 4,
  parameter int AGE_MAX = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [PKT_W-1:0] rsp_pkt,
  input  logic             fwd_valid,
  output logic             fwd_ready,
  input  logic [PKT_W-1:0] fwd_pkt,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PKT_W-1:0] req_pkt,
  output logic             noc_valid,
  input  logic             noc_ready,
  output logic [PKT_W-1:0] noc_pkt,
  output logic [1:0]       noc_src
);

  // Source class carried alongside the message. The encoding 2'd3 is never
  // produced.
  typedef enum logic [1:0] {
    SRC_RSP = 2'd0,
    SRC_FWD = 2'd1,
    SRC_REQ = 2'd2
  } src_e;

  // Output stage registers.
  logic             noc_valid_q, noc_valid_d;
  logic [PKT_W-1:0] noc_pkt_q,   noc_pkt_d;
  src_e             noc_src_q,   noc_src_d;

  // Arbitration signals.
  logic load_en;
  logic grant_rsp;
  logic grant_fwd;
  logic grant_req;
  logic any_grant;
  logic req_promoted;

`ifdef L2_OUT_AGING_EN
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(AGE_MAX);

  logic [AGE_W-1:0] age_q, age_d;

  // A request is promoted only while it is still pending. The counter clears
  // when req_valid drops, so this guard matters only in the cycle right after
  // a source withdraws its request.
  always_comb begin
    req_promoted = req_valid && (age_q == AGE_LIMIT);
  end

  // The starvation counter grows on every refused request cycle and saturates
  // at the limit. It restarts when the request goes through or goes away.
  always_comb begin
    age_d = age_q;
    if (!req_valid || req_ready) begin
      age_d = '0;
    end else if (age_q != AGE_LIMIT) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  // Without aging, req always ranks below fwd.
  always_comb begin
    req_promoted = 1'b0;
  end
`endif

  // Fixed-priority grant. The grant uses only the valids and the aging
  // promotion. It never looks at any message contents.
  always_comb begin
    grant_rsp = 1'b0;
    grant_fwd = 1'b0;
    grant_req = 1'b0;
    if (rsp_valid) begin
      grant_rsp = 1'b1;
    end else if (req_promoted) begin
      grant_req = 1'b1;
    end else if (fwd_valid) begin
      grant_fwd = 1'b1;
    end else if (req_valid) begin
      grant_req = 1'b1;
    end
    any_grant = grant_rsp || grant_fwd || grant_req;
  end

  // The stage can accept a message when it is empty or is being drained in
  // this same cycle. Loading while draining gives full throughput.
  always_comb begin
    load_en   = !noc_valid_q || noc_ready;
    rsp_ready = load_en && grant_rsp;
    fwd_ready = load_en && grant_fwd;
    req_ready = load_en && grant_req;
  end

  // Next state of the output stage. When a slot is offered but no message is
  // granted, the stage empties. The old message and tag are left in place so
  // that the data bus does not toggle for no reason.
  always_comb begin
    noc_valid_d = noc_valid_q;
    noc_pkt_d   = noc_pkt_q;
    noc_src_d   = noc_src_q;
    if (load_en) begin
      noc_valid_d = any_grant;
      if (grant_rsp) begin
        noc_pkt_d = rsp_pkt;
        noc_src_d = SRC_RSP;
      end else if (grant_fwd) begin
        noc_pkt_d = fwd_pkt;
        noc_src_d = SRC_FWD;
      end else if (grant_req) begin
        noc_pkt_d = req_pkt;
        noc_src_d = SRC_REQ;
      end
    end
  end

  // Output stage registers. Reset discards any message held in the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noc_valid_q <= 1'b0;
      noc_pkt_q   <= '0;
      noc_src_q   <= SRC_RSP;
    end else begin
      noc_valid_q <= noc_valid_d;
      noc_pkt_q   <= noc_pkt_d;
      noc_src_q   <= noc_src_d;
    end
  end

  // Drive the outputs.
  always_comb begin
    noc_valid = noc_valid_q;
    noc_pkt   = noc_pkt_q;
    noc_src   = noc_src_q;
  end

endmodule

// File: tb/tb_l2_out_arbiter.sv
// Directed testbench for l2_out_arbiter. The test expectations change when
// L2_OUT_AGING_EN is defined.
module tb_l2_out_arbiter;

  localparam int PKT_W   = 600;
  localparam int AGE_MAX = 12;

  logic             clk;
  logic             rst;
  logic             rsp_valid, fwd_valid, req_valid;
  logic             rsp_ready, fwd_ready, req_ready;
  logic [PKT_W-1:0] rsp_pkt, fwd_pkt, req_pkt;
  logic             noc_valid, noc_ready;
  logic [PKT_W-1:0] noc_pkt;
  logic [1:0]       noc_src;

  int total;
  int bad;

  l2_out_arbiter #(.PKT_W(PKT_W), .AGE_W(4), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rst(rst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pkt(rsp_pkt),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_pkt(fwd_pkt),
    .req_valid(req_valid), .req_ready(req_ready), .req_pkt(req_pkt),
    .noc_valid(noc_valid), .noc_ready(noc_ready), .noc_pkt(noc_pkt),
    .noc_src(noc_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Moves 1 time unit past the next rising edge, so that inputs change and
  // outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsp_valid = 1'b0; fwd_valid = 1'b0; req_valid = 1'b0;
    rsp_pkt = '0; fwd_pkt = '0; req_pkt = '0;
    noc_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (noc_valid !== 1'b0 || noc_pkt !== '0 || noc_src !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got v=%b src=%0d pkt=%0h, want v=0 src=0 pkt=0",
               noc_valid, noc_src, noc_pkt);
    end
    total++;
    if ({rsp_ready, fwd_ready, req_ready} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_readies: got %b want 000", {rsp_ready, fwd_ready, req_ready});
    end
    tick();
  endtask

  task automatic test_single_req();
    req_valid = 1'b1; req_pkt = PKT_W'(8'h5A); noc_ready = 1'b1;
    #1;
    total++;
    if ({rsp_ready, fwd_ready, req_ready} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL single_req_ready: got %b want 001", {rsp_ready, fwd_ready, req_ready});
    end
    tick();
    req_valid = 1'b0;
    total++;
    if (noc_valid !== 1'b1 || noc_pkt !== PKT_W'(8'h5A) || noc_src !== 2'd2) begin
      bad++;
      $display("[TB] FAIL single_req_out: got v=%b src=%0d pkt=%0h, want v=1 src=2 pkt=5a",
               noc_valid, noc_src, noc_pkt);
    end
    tick();
    total++;
    if (noc_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_req_drain: got v=%b want 0", noc_valid);
    end
  endtask

  task automatic test_all_three();
    logic [1:0]       exp_src [3];
    logic [PKT_W-1:0] exp_pkt [3];
    exp_src[0] = 2'd0; exp_pkt[0] = PKT_W'(12'h111);
    exp_src[1] = 2'd1; exp_pkt[1] = PKT_W'(12'h222);
    exp_src[2] = 2'd2; exp_pkt[2] = PKT_W'(12'h333);
    rsp_valid = 1'b1; rsp_pkt = exp_pkt[0];
    fwd_valid = 1'b1; fwd_pkt = exp_pkt[1];
    req_valid = 1'b1; req_pkt = exp_pkt[2];
    noc_ready = 1'b1;
    #1;
    total++;
    if ({rsp_ready, fwd_ready, req_ready} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL all3_first_grant: got %b want 100", {rsp_ready, fwd_ready, req_ready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) rsp_valid = 1'b0;
      if (i == 1) fwd_valid = 1'b0;
      if (i == 2) req_valid = 1'b0;
      total++;
      if (noc_valid !== 1'b1 || noc_src !== exp_src[i] || noc_pkt !== exp_pkt[i]) begin
        bad++;
        $display("[TB] FAIL all3_order[%0d]: got v=%b src=%0d pkt=%0h, want v=1 src=%0d pkt=%0h",
                 i, noc_valid, noc_src, noc_pkt, exp_src[i], exp_pkt[i]);
      end
    end
    tick();
    total++;
    if (noc_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL all3_drain: got v=%b want 0", noc_valid);
    end
  endtask

  task automatic test_backpressure();
    noc_ready = 1'b0;
    rsp_valid = 1'b1; rsp_pkt = PKT_W'(8'hAA);
    #1;
    total++;
    if (rsp_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_empty_load: got rsp_ready=%b want 1", rsp_ready);
    end
    tick();
    rsp_pkt = PKT_W'(8'hB1);
    fwd_valid = 1'b1; fwd_pkt = PKT_W'(8'hB2);
    req_valid = 1'b1; req_pkt = PKT_W'(8'hB3);
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({rsp_ready, fwd_ready, req_ready} !== 3'b000 || noc_valid !== 1'b1 ||
          noc_pkt !== PKT_W'(8'hAA) || noc_src !== 2'd0) begin
        bad++;
        $display("[TB] FAIL bp_hold[%0d]: got rdy=%b v=%b src=%0d pkt=%0h, want rdy=000 v=1 src=0 pkt=aa",
                 c, {rsp_ready, fwd_ready, req_ready}, noc_valid, noc_src, noc_pkt);
      end
      tick();
    end
    noc_ready = 1'b1;
    #1;
    total++;
    if ({rsp_ready, fwd_ready, req_ready} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL bp_release_ready: got %b want 100", {rsp_ready, fwd_ready, req_ready});
    end
    tick();
    rsp_valid = 1'b0;
    total++;
    if (noc_valid !== 1'b1 || noc_pkt !== PKT_W'(8'hB1) || noc_src !== 2'd0) begin
      bad++;
      $display("[TB] FAIL bp_reload: got v=%b src=%0d pkt=%0h, want v=1 src=0 pkt=b1",
               noc_valid, noc_src, noc_pkt);
    end
    tick();
    fwd_valid = 1'b0;
    total++;
    if (noc_pkt !== PKT_W'(8'hB2) || noc_src !== 2'd1) begin
      bad++;
      $display("[TB] FAIL bp_fwd: got src=%0d pkt=%0h, want src=1 pkt=b2", noc_src, noc_pkt);
    end
    tick();
    req_valid = 1'b0;
    total++;
    if (noc_pkt !== PKT_W'(8'hB3) || noc_src !== 2'd2) begin
      bad++;
      $display("[TB] FAIL bp_req: got src=%0d pkt=%0h, want src=2 pkt=b3", noc_src, noc_pkt);
    end
    tick();
  endtask

  task automatic test_starvation();
    int req_grants;
    fwd_valid = 1'b1; fwd_pkt = PKT_W'(8'hF0);
    req_valid = 1'b1; req_pkt = PKT_W'(8'hE0);
    noc_ready = 1'b1;
`ifdef L2_OUT_AGING_EN
    for (int k = 0; k <= AGE_MAX; k++) begin
      #1;
      total++;
      if (k < AGE_MAX && {fwd_ready, req_ready} !== 2'b10) begin
        bad++;
        $display("[TB] FAIL age_fwd_first[%0d]: got fr=%b rr=%b want 10", k, fwd_ready, req_ready);
      end else if (k == AGE_MAX && {fwd_ready, req_ready} !== 2'b01) begin
        bad++;
        $display("[TB] FAIL age_req_grant[%0d]: got fr=%b rr=%b want 01", k, fwd_ready, req_ready);
      end
      tick();
    end
    req_valid = 1'b0;
    total++;
    if (noc_src !== 2'd2 || noc_pkt !== PKT_W'(8'hE0)) begin
      bad++;
      $display("[TB] FAIL age_req_out: got src=%0d pkt=%0h want src=2 pkt=e0", noc_src, noc_pkt);
    end
`else
    req_grants = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req_ready === 1'b1) req_grants++;
      total++;
      if (fwd_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL starve_fwd[%0d]: got fr=%b want 1", k, fwd_ready);
      end
      tick();
    end
    total++;
    if (req_grants !== 0) begin
      bad++;
      $display("[TB] FAIL starve_req: got %0d req grants want 0", req_grants);
    end
    req_valid = 1'b0;
`endif
    fwd_valid = 1'b0;
    tick();
  endtask

`ifdef L2_OUT_AGING_EN
  task automatic test_rsp_vs_aged();
    fwd_valid = 1'b1; fwd_pkt = PKT_W'(8'hF1);
    req_valid = 1'b1; req_pkt = PKT_W'(8'hE1);
    noc_ready = 1'b1;
    repeat (AGE_MAX) tick();
    total++;
    if (dut.age_q !== 4'(AGE_MAX)) begin
      bad++;
      $display("[TB] FAIL aged_count: got %0d want %0d", dut.age_q, AGE_MAX);
    end
    rsp_valid = 1'b1; rsp_pkt = PKT_W'(8'hC1);
    #1;
    total++;
    if ({rsp_ready, fwd_ready, req_ready} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL aged_rsp_first: got %b want 100", {rsp_ready, fwd_ready, req_ready});
    end
    tick();
    rsp_valid = 1'b0;
    #1;
    total++;
    if ({rsp_ready, fwd_ready, req_ready} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL aged_req_next: got %b want 001", {rsp_ready, fwd_ready, req_ready});
    end
    tick();
    req_valid = 1'b0;
    fwd_valid = 1'b0;
    total++;
    if (noc_src !== 2'd2 || noc_pkt !== PKT_W'(8'hE1)) begin
      bad++;
      $display("[TB] FAIL aged_req_out: got src=%0d pkt=%0h want src=2 pkt=e1", noc_src, noc_pkt);
    end
    tick();
  endtask
`endif

  task automatic test_reset_midflight();
    noc_ready = 1'b0;
    rsp_valid = 1'b1; rsp_pkt = PKT_W'(8'hD7);
    tick();
    rsp_valid = 1'b0;
    req_valid = 1'b1; req_pkt = PKT_W'(8'hD8);
    tick();
    tick();
    tick();
    total++;
    if (noc_valid !== 1'b1 || noc_pkt !== PKT_W'(8'hD7)) begin
      bad++;
      $display("[TB] FAIL midrst_full: got v=%b pkt=%0h want v=1 pkt=d7", noc_valid, noc_pkt);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (noc_valid !== 1'b0 || noc_pkt !== '0 || noc_src !== 2'd0) begin
      bad++;
      $display("[TB] FAIL midrst_clear: got v=%b src=%0d pkt=%0h want v=0 src=0 pkt=0",
               noc_valid, noc_src, noc_pkt);
    end
`ifdef L2_OUT_AGING_EN
    total++;
    if (dut.age_q !== 4'd0) begin
      bad++;
      $display("[TB] FAIL midrst_age: got %0d want 0", dut.age_q);
    end
`endif
    clear_inputs();
    tick();
    #2;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_req();
    test_all_three();
    test_backpressure();
    test_reset();
    test_starvation();
`ifdef L2_OUT_AGING_EN
    test_reset();
    test_rsp_vs_aged();
`endif
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
